pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Parametrised program-counter and fetch-request controller for the rv32 fetch stage. It holds the PC and issues fetch requests to instruction memory over a valid/ready handshake. It arbitrates several prioritised redirect sources (branch, jump, trap), and supports stall, halt/resume and boot sequencing. It also flags misaligned redirect targets and counts accepted fetches.

## Interface
- XLEN, 32, address/PC width
- RESET_VEC, 32'h0000_0000, PC value loaded on reset
- INC, 4, byte increment per sequential fetch; power of two, 2..8
- NRDR, 3, number of redirect sources; index 0 has highest priority
- CNT_W, 16, width of accepted-fetch counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard-unit hold; blocks acceptance and PC advance
- halt  in  1  enter HALT after the current cycle (WFI/ebreak)
- redir_valid  in  NRDR  per-source redirect request
- redir_target  in  NRDR*XLEN  per-source target; source i at bits [i*XLEN +: XLEN]
- fetch_ready  in  1  imem accepts request this cycle
- fetch_valid  out  1  fetch request valid
- fetch_pc  out  XLEN  address of current request
- fetch_pc_nxt  out  XLEN  fetch_pc + INC, combinational, wraps mod 2^XLEN
- halted  out  1  high while in HALT
- misalign_err  out  1  one-cycle pulse: a taken redirect target had nonzero low bits
- err_addr  out  XLEN  unmasked target that caused the last misalign_err
- fetch_count  out  CNT_W  number of accepted fetches, wraps

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- accept = fetch_valid & fetch_ready & ~stall.
- Redirect selection:
  - The taken source is the lowest index with redir_valid set.
  - Its target has low log2(INC) bits forced to 0 before loading.
  - If those bits were nonzero: misalign_err pulses next cycle and err_addr captures the raw target.
- PC update priority, highest first:
  - 1. rst
  - 2. taken redirect: fetch_pc <= masked target. Applies in any state, and with stall or halt asserted.
  - 3. accept: fetch_pc <= fetch_pc_nxt.
  - 4. otherwise hold.
- BOOT:
  - fetch_valid=0 for exactly one cycle, then RUN.
  - A redirect in BOOT loads its target and goes to RUN.
- RUN:
  - fetch_valid=1.
  - halt=1 with no redirect: go to HALT next cycle. An accept in the same cycle still advances the PC and the counter.
  - halt together with a redirect: redirect wins, halt is ignored, stay in RUN.
- HALT:
  - fetch_valid=0, halted=1, PC held.
  - Any redirect loads its target and returns to RUN. halt is ignored while halted.
- Handshake:
  - While fetch_valid=1 and not accepted, fetch_pc is stable unless a redirect occurs.
  - A redirect kills the pending request: fetch_pc changes without acceptance and fetch_valid stays 1.
- fetch_count increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values: fetch_pc=RESET_VEC, fetch_valid=0, halted=0, misalign_err=0, err_addr=0, fetch_count=0, state=BOOT.
- All outputs are registered except fetch_pc_nxt.
- Redirect-to-fetch latency is 1 cycle: target appears on fetch_pc the cycle after redir_valid.
- Sequential throughput is one fetch per cycle when fetch_ready=1 and stall=0.
- rst asserted mid-transfer drops fetch_valid immediately, asynchronously. No partial state survives.
- PC wrap: fetch_pc = 2^XLEN - INC accepted gives next fetch_pc = 0, with no error.

## Structure
- Package pc_pkg holds:
  - the state enum (BOOT, RUN, HALT)
  - the default RESET_VEC
  - the redirect-source index constants: RDR_TRAP=0, RDR_JUMP=1, RDR_BRANCH=2
- Sub-module pc_redir_arb is a combinational fixed-priority selector. It outputs taken, masked target, raw target and misalign flag.
- The top level holds the FSM, the PC register, the error registers and the counter.

## Test plan
- Reset, release, fetch_ready=1 for 4 cycles:
  - BOOT cycle has fetch_valid=0.
  - Then fetch_pc = 0, 4, 8, 12.
  - fetch_count=3 at the end.
- fetch_ready=0 for 3 cycles at pc=0x10:
  - fetch_pc stays 0x10 and fetch_count is unchanged.
  - Raise fetch_ready: next pc is 0x14.
- redir_valid=3'b110, targets src1=0x200, src2=0x300, with stall=1: next fetch_pc=0x200 and fetch_count is unchanged.
- Redirect to 0x102 on src2: fetch_pc=0x100, misalign_err pulses one cycle, err_addr=0x102.
- halt with accept at pc=0x40:
  - pc advances to 0x44, then halted=1 and fetch_valid=0 for 5 cycles.
  - Redirect src0 to 0x80: RUN next cycle with fetch_pc=0x80.
- fetch_pc=0xFFFF_FFFC accepted: next fetch_pc=0. Assert rst mid-stream: fetch_valid drops the same cycle and all outputs return to reset values.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the rv32 fetch-stage PC controller
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

  // Redirect source indices; a lower index wins arbitration.
  localparam int unsigned RDR_TRAP   = 0;
  localparam int unsigned RDR_JUMP   = 1;
  localparam int unsigned RDR_BRANCH = 2;

endpackage

// File: rtl/pc_redir_arb.sv
// rtl/pc_redir_arb.sv - combinational fixed-priority redirect selector with alignment masking
module pc_redir_arb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned INC  = 4,
  parameter int unsigned NRDR = 3
) (
  input  logic [NRDR-1:0]      valid_i,
  input  logic [NRDR*XLEN-1:0] target_i,
  output logic                 taken_o,
  output logic [XLEN-1:0]      masked_o,
  output logic [XLEN-1:0]      raw_o,
  output logic                 misalign_o
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);

  // Scan from the lowest priority upward so the lowest valid index is written last.
  always_comb begin
    taken_o = 1'b0;
    raw_o   = '0;
    for (int i = NRDR - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        taken_o = 1'b1;
        raw_o   = target_i[i*XLEN +: XLEN];
      end
    end
  end

  assign masked_o   = raw_o & ~LOW_MASK;
  assign misalign_o = taken_o & (|(raw_o & LOW_MASK));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and fetch-request controller for the rv32 fetch stage
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter int unsigned     INC       = 4,
  parameter int unsigned     NRDR      = 3,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 halt,
  input  logic [NRDR-1:0]      redir_valid,
  input  logic [NRDR*XLEN-1:0] redir_target,
  input  logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [XLEN-1:0]      fetch_pc,
  output logic [XLEN-1:0]      fetch_pc_nxt,
  output logic                 halted,
  output logic                 misalign_err,
  output logic [XLEN-1:0]      err_addr,
  output logic [CNT_W-1:0]     fetch_count
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic             mis_q, mis_d;
  logic [XLEN-1:0]  err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rdr_taken;
  logic [XLEN-1:0]  rdr_masked;
  logic [XLEN-1:0]  rdr_raw;
  logic             rdr_misalign;
  logic             accept;

  pc_redir_arb #(
    .XLEN (XLEN),
    .INC  (INC),
    .NRDR (NRDR)
  ) u_arb (
    .valid_i    (redir_valid),
    .target_i   (redir_target),
    .taken_o    (rdr_taken),
    .masked_o   (rdr_masked),
    .raw_o      (rdr_raw),
    .misalign_o (rdr_misalign)
  );

  assign accept       = valid_q & fetch_ready & ~stall;
  assign fetch_pc_nxt = pc_q + XLEN'(INC);

  // A redirect always forces RUN, so it overrides halt in RUN and wakes HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!rdr_taken && halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (rdr_taken) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (rdr_taken) begin
      pc_d = rdr_masked;
    end else if (accept) begin
      pc_d = fetch_pc_nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    valid_d  = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
    mis_d    = rdr_taken & rdr_misalign;
    err_d    = (rdr_taken & rdr_misalign) ? rdr_raw : err_q;
    cnt_d    = accept ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VEC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fetch_valid  = valid_q;
  assign fetch_pc     = pc_q;
  assign halted       = halted_q;
  assign misalign_err = mis_q;
  assign err_addr     = err_q;
  assign fetch_count  = cnt_q;

endmodule
